tc_mul_rx: RTL and testbench

TC_MUL_RX -- requirements
Module: tc_mul_rx

---
 rtl/tc_mul_rx_pkg.sv | 35 +++
 rtl/tc_mul_rx_slot.sv | 42 ++++
 rtl/tc_mul_rx.sv | 184 ++++++++++++++++++
 tb/tb_tc_mul_rx.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_mul_rx_pkg.sv
// ---------------------------------------------------------------------------
// tc_pkg -- shared types for the tensor-core multiplier receive serializer.
//
// Holds the default geometry constants, the two-state serializer FSM enum and
// the packed slot record used for both the ACTIVE and PENDING vector buffers.
// The tc_mul_rx parameters default to the constants below, and the slot
// struct is sized from them.
//
// Configuration macro: TC_MUL_RX_FFLAGS_EN (see tc_mul_rx.sv). The fflags
// field stays in the struct in either build. When the macro is undefined it
// is loaded with zero, so it reduces to constants.
// ---------------------------------------------------------------------------
package tc_pkg;

    localparam int TC_SHAPE_K       = 8;
    localparam int TC_ELEMENT_WIDTH = 9;
    localparam int TC_CTRL_C_WIDTH  = 16;
    localparam int TC_DEPTH_WARP    = 4;
    localparam int TC_FFLAGS_WIDTH  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tc_state_e;

    typedef struct packed {
        logic [TC_SHAPE_K*TC_ELEMENT_WIDTH-1:0] data;
        logic [TC_FFLAGS_WIDTH-1:0]             fflags;
        logic [TC_CTRL_C_WIDTH-1:0]             ctrl_c;
        logic [2:0]                             ctrl_rm;
        logic [7:0]                             reg_idxw;
        logic [TC_DEPTH_WARP-1:0]               warpid;
    } tc_slot_t;

endpackage

// File: rtl/tc_mul_rx_slot.sv
// ---------------------------------------------------------------------------
// tc_mul_rx_slot -- one vector buffer (payload record plus valid flag).
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (clears payload and valid)
//   load       in   capture slot_d and mark the slot full
//   clear      in   mark the slot empty (payload left as is)
//   slot_d     in   record to capture
//   slot_q     out  stored record
//   slot_valid out  slot holds a vector
//
// Configuration macro TC_MUL_RX_FFLAGS_EN is handled by the top level. This
// block simply stores whatever record it is given.
// ---------------------------------------------------------------------------
module tc_mul_rx_slot
    import tc_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  logic     clear,
    input  tc_slot_t slot_d,
    output tc_slot_t slot_q,
    output logic     slot_valid
);

    // load wins over clear. The top level uses that when it refills a slot
    // in the same cycle it would otherwise retire it.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q     <= '0;
            slot_valid <= 1'b0;
        end else if (load) begin
            slot_q     <= slot_d;
            slot_valid <= 1'b1;
        end else if (clear) begin
            slot_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/tc_mul_rx.sv
// ---------------------------------------------------------------------------
// tc_mul_rx -- serializes multiplier product vectors into per-lane beats.
//
// Each accepted vector is emitted as SHAPE_K beats, lane 0 first. Two buffers
// are used. ACTIVE holds the vector being emitted. PENDING holds the next one.
// With this arrangement, consecutive vectors stream with no bubble cycles.
//
// Ports:
//   clk, rst                      clock / synchronous active-high reset
//   in_valid_i, in_ready_o        input vector handshake
//   result_i                      product vector, lane i at [(i+1)*EW-1 -: EW]
//   fflags_i                      OR-reduced exception flags of the vector
//   ctrl_c_i, ctrl_rm_i,
//   ctrl_reg_idxw_i, ctrl_warpid_i  control sideband travelling with vector
//   out_valid_o, out_ready_i      per-lane beat handshake
//   out_data_o, out_lane_o        current lane value and its index
//   out_last_o                    high on lane SHAPE_K-1
//   out_fflags_o                  vector flags (last beat only, when enabled)
//   ctrl_*_o                      sideband of the vector being emitted
//
// Configuration macro TC_MUL_RX_FFLAGS_EN:
//   defined   -> fflags are stored and shown on the last beat of the vector
//   undefined -> out_fflags_o tied to 0, fflags_i ignored
// ---------------------------------------------------------------------------
module tc_mul_rx
    import tc_pkg::*;
#(
    parameter int SHAPE_K       = TC_SHAPE_K,
    parameter int ELEMENT_WIDTH = TC_ELEMENT_WIDTH,
    parameter int CTRL_C_WIDTH  = TC_CTRL_C_WIDTH,
    parameter int DEPTH_WARP    = TC_DEPTH_WARP,
    parameter int LW            = $clog2(SHAPE_K)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [SHAPE_K*ELEMENT_WIDTH-1:0] result_i,
    input  logic [4:0]                       fflags_i,
    input  logic [CTRL_C_WIDTH-1:0]          ctrl_c_i,
    input  logic [2:0]                       ctrl_rm_i,
    input  logic [7:0]                       ctrl_reg_idxw_i,
    input  logic [DEPTH_WARP-1:0]            ctrl_warpid_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [ELEMENT_WIDTH-1:0]         out_data_o,
    output logic [LW-1:0]                    out_lane_o,
    output logic                             out_last_o,
    output logic [4:0]                       out_fflags_o,
    output logic [CTRL_C_WIDTH-1:0]          ctrl_c_o,
    output logic [2:0]                       ctrl_rm_o,
    output logic [7:0]                       ctrl_reg_idxw_o,
    output logic [DEPTH_WARP-1:0]            ctrl_warpid_o
);

    tc_state_e     state, state_next;
    logic [LW-1:0] lane, lane_next;

    tc_slot_t in_slot, act_d, act_q, pend_q;
    logic     act_load, act_clear, act_from_pend;
    logic     pend_load, pend_clear, pend_valid;
    logic     act_valid_unused;
    logic     in_fire, out_fire, last_fire;

    // Pack the incoming vector and its sideband into one slot record.
    always_comb begin
        in_slot          = '0;
        in_slot.data     = result_i;
        in_slot.ctrl_c   = ctrl_c_i;
        in_slot.ctrl_rm  = ctrl_rm_i;
        in_slot.reg_idxw = ctrl_reg_idxw_i;
        in_slot.warpid   = ctrl_warpid_i;
`ifdef TC_MUL_RX_FFLAGS_EN
        in_slot.fflags   = fflags_i;
`endif
    end

`ifndef TC_MUL_RX_FFLAGS_EN
    logic unused_fflags;
    assign unused_fflags = ^{fflags_i, act_q.fflags};
`endif

    // in_ready_o depends on registered state only. A free ACTIVE slot is
    // always backed by a free PENDING slot, so PENDING alone decides it.
    assign in_ready_o = !pend_valid;
    assign in_fire    = in_valid_i && in_ready_o;
    assign out_fire   = (state == SEND) && out_ready_i;
    assign last_fire  = out_fire && (lane == LW'(SHAPE_K - 1));

    assign act_d = act_from_pend ? pend_q : in_slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            lane  <= '0;
        end else begin
            state <= state_next;
            lane  <= lane_next;
        end
    end

    // On the last beat, ACTIVE refills first from PENDING. If PENDING is
    // empty, a vector arriving in that same cycle goes straight into ACTIVE,
    // which keeps back-to-back streaming free of bubbles.
    always_comb begin
        state_next    = state;
        lane_next     = lane;
        act_load      = 1'b0;
        act_clear     = 1'b0;
        act_from_pend = 1'b0;
        pend_load     = 1'b0;
        pend_clear    = 1'b0;
        case (state)
            IDLE: begin
                if (in_fire) begin
                    act_load   = 1'b1;
                    lane_next  = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (last_fire) begin
                    lane_next = '0;
                    if (pend_valid) begin
                        act_load      = 1'b1;
                        act_from_pend = 1'b1;
                        pend_clear    = 1'b1;
                    end else if (in_fire) begin
                        act_load = 1'b1;
                    end else begin
                        act_clear  = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    if (out_fire) begin
                        lane_next = lane + LW'(1);
                    end
                    if (in_fire) begin
                        pend_load = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    tc_mul_rx_slot u_active (
        .clk        (clk),
        .rst        (rst),
        .load       (act_load),
        .clear      (act_clear),
        .slot_d     (act_d),
        .slot_q     (act_q),
        .slot_valid (act_valid_unused)
    );

    tc_mul_rx_slot u_pending (
        .clk        (clk),
        .rst        (rst),
        .load       (pend_load),
        .clear      (pend_clear),
        .slot_d     (in_slot),
        .slot_q     (pend_q),
        .slot_valid (pend_valid)
    );

    assign out_valid_o     = (state == SEND);
    assign out_lane_o      = lane;
    assign out_last_o      = (lane == LW'(SHAPE_K - 1)) && (state == SEND);
    assign out_data_o      = ELEMENT_WIDTH'(act_q.data >> (lane * ELEMENT_WIDTH));
    assign ctrl_c_o        = act_q.ctrl_c;
    assign ctrl_rm_o       = act_q.ctrl_rm;
    assign ctrl_reg_idxw_o = act_q.reg_idxw;
    assign ctrl_warpid_o   = act_q.warpid;

`ifdef TC_MUL_RX_FFLAGS_EN
    assign out_fflags_o = out_last_o ? act_q.fflags : 5'd0;
`else
    assign out_fflags_o = 5'd0;
`endif

endmodule

// File: tb/tb_tc_mul_rx.sv
// ---------------------------------------------------------------------------
// tb_tc_mul_rx -- self-checking bench for tc_mul_rx.
// The reference model is a queue of expected beats. An accepted vector
// appends SHAPE_K beats, and each output handshake pops one. Readiness is
// derived from how many vectors are still queued.
// ---------------------------------------------------------------------------
module tb_tc_mul_rx;

    localparam int K  = 8;
    localparam int EW = 9;
    localparam int CW = 16;
    localparam int DW = 4;
    localparam int LW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [K*EW-1:0] result_i;
    logic [4:0]      fflags_i;
    logic [CW-1:0]   ctrl_c_i;
    logic [2:0]      ctrl_rm_i;
    logic [7:0]      ctrl_reg_idxw_i;
    logic [DW-1:0]   ctrl_warpid_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [EW-1:0]   out_data_o;
    logic [LW-1:0]   out_lane_o;
    logic            out_last_o;
    logic [4:0]      out_fflags_o;
    logic [CW-1:0]   ctrl_c_o;
    logic [2:0]      ctrl_rm_o;
    logic [7:0]      ctrl_reg_idxw_o;
    logic [DW-1:0]   ctrl_warpid_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [EW-1:0] data;
        logic [LW-1:0] lane;
        logic          last;
        logic [4:0]    fflags;
        logic [CW-1:0] ctrl_c;
        logic [2:0]    rm;
        logic [7:0]    idxw;
        logic [DW-1:0] warpid;
    } beat_t;

    beat_t beats[$];

    always #5 clk = ~clk;

    tc_mul_rx dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .result_i        (result_i),
        .fflags_i        (fflags_i),
        .ctrl_c_i        (ctrl_c_i),
        .ctrl_rm_i       (ctrl_rm_i),
        .ctrl_reg_idxw_i (ctrl_reg_idxw_i),
        .ctrl_warpid_i   (ctrl_warpid_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_data_o      (out_data_o),
        .out_lane_o      (out_lane_o),
        .out_last_o      (out_last_o),
        .out_fflags_o    (out_fflags_o),
        .ctrl_c_o        (ctrl_c_o),
        .ctrl_rm_o       (ctrl_rm_o),
        .ctrl_reg_idxw_o (ctrl_reg_idxw_o),
        .ctrl_warpid_o   (ctrl_warpid_o)
    );

    // Number of vectors still owed to the output, including a partly sent one.
    function automatic int held();
        return (beats.size() + K - 1) / K;
    endfunction

    function automatic logic model_ready();
        return held() < 2;
    endfunction

    function automatic void push_vector();
        beat_t b;
        for (int i = 0; i < K; i++) begin
            b.data   = result_i[i*EW +: EW];
            b.lane   = LW'(i);
            b.last   = (i == K - 1);
`ifdef TC_MUL_RX_FFLAGS_EN
            b.fflags = (i == K - 1) ? fflags_i : 5'd0;
`else
            b.fflags = 5'd0;
`endif
            b.ctrl_c = ctrl_c_i;
            b.rm     = ctrl_rm_i;
            b.idxw   = ctrl_reg_idxw_i;
            b.warpid = ctrl_warpid_i;
            beats.push_back(b);
        end
    endfunction

    // Clock the model and DUT together. Called at a falling edge and
    // returns at the next falling edge.
    task automatic advance();
        bit in_fire, out_fire;
        in_fire  = in_valid_i && model_ready() && !rst;
        out_fire = (beats.size() > 0) && out_ready_i && !rst;
        @(posedge clk);
        if (rst) begin
            beats.delete();
        end else begin
            if (out_fire) beats.delete(0);
            if (in_fire) push_vector();
        end
        @(negedge clk);
    endtask

    task automatic rand_vector();
        for (int i = 0; i < K; i++) result_i[i*EW +: EW] = EW'($urandom);
        fflags_i        = 5'($urandom);
        ctrl_c_i        = CW'($urandom);
        ctrl_rm_i       = 3'($urandom);
        ctrl_reg_idxw_i = 8'($urandom);
        ctrl_warpid_i   = DW'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
        rand_vector();
        advance();
        advance();
        rst = 1'b0;
        checks++;
        if ({out_valid_o, out_last_o, out_lane_o} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got valid/last/lane=%b want 00000",
                     {out_valid_o, out_last_o, out_lane_o});
        end
        checks++;
        if ({out_data_o, out_fflags_o} !== 14'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: got data=%h fflags=%b want 0", out_data_o, out_fflags_o);
        end
        checks++;
        if ({ctrl_c_o, ctrl_rm_o, ctrl_reg_idxw_o, ctrl_warpid_o} !== 31'd0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got c=%h rm=%h idxw=%h warp=%h want 0",
                     ctrl_c_o, ctrl_rm_o, ctrl_reg_idxw_o, ctrl_warpid_o);
        end
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b want 1", in_ready_o);
        end
    endtask

    task automatic test_single();
        rand_vector();
        for (int i = 0; i < K; i++) result_i[i*EW +: EW] = EW'(i + 1);
        in_valid_i = 1'b1; out_ready_i = 1'b1;
        advance();
        in_valid_i = 1'b0;
        for (int c = 1; c <= K + 2; c++) begin
            checks++;
            if (out_valid_o !== (c <= K)) begin
                errors++;
                $display("[TB] FAIL single_valid c=%0d: got %b want %b", c, out_valid_o, (c <= K));
            end
            if (c <= K) begin
                checks++;
                if ({out_data_o, out_lane_o, out_last_o} !== {EW'(c), LW'(c - 1), (c == K)}) begin
                    errors++;
                    $display("[TB] FAIL single_beat c=%0d: got data=%h lane=%0d last=%b want data=%h lane=%0d last=%b",
                             c, out_data_o, out_lane_o, out_last_o, c, c - 1, (c == K));
                end
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        int  sent, run, best;
        bit  fire;
        sent = 0; run = 0; best = 0;
        rand_vector();
        for (int i = 0; i < K; i++) result_i[i*EW +: EW] = EW'(9'h010 + i);
        in_valid_i = 1'b1; out_ready_i = 1'b1;
        for (int c = 0; c < 22; c++) begin
            checks++;
            if ({in_ready_o, out_valid_o} !== {model_ready(), beats.size() > 0}) begin
                errors++;
                $display("[TB] FAIL b2b_hs c=%0d: got ready/valid=%b%b want %b%b",
                         c, in_ready_o, out_valid_o, model_ready(), beats.size() > 0);
            end
            if (beats.size() > 0) begin
                checks++;
                if ({out_data_o, out_lane_o, out_last_o} !== {beats[0].data, beats[0].lane, beats[0].last}) begin
                    errors++;
                    $display("[TB] FAIL b2b_beat c=%0d: got %h/%0d/%b want %h/%0d/%b", c,
                             out_data_o, out_lane_o, out_last_o, beats[0].data, beats[0].lane, beats[0].last);
                end
            end
            run  = out_valid_o ? run + 1 : 0;
            best = (run > best) ? run : best;
            fire = in_valid_i && model_ready();
            advance();
            if (fire) begin
                sent++;
                if (sent == 1) begin
                    rand_vector();
                    for (int i = 0; i < K; i++) result_i[i*EW +: EW] = EW'(9'h020 + i);
                end else begin
                    in_valid_i = 1'b0;
                end
            end
        end
        checks++;
        if (best !== 2 * K) begin
            errors++;
            $display("[TB] FAIL b2b_stream: got %0d consecutive beats want %0d", best, 2 * K);
        end
    endtask

    task automatic test_stall();
        int fired;
        fired = 0;
        rand_vector();
        in_valid_i = 1'b1; out_ready_i = 1'b0;
        advance();
        in_valid_i = 1'b0;
        for (int c = 0; c < 2 * K + 2; c++) begin
            out_ready_i = (c % 2 == 1);
            checks++;
            if (out_valid_o !== (beats.size() > 0)) begin
                errors++;
                $display("[TB] FAIL stall_valid c=%0d: got %b want %b", c, out_valid_o, beats.size() > 0);
            end
            if (beats.size() > 0) begin
                checks++;
                if ({out_data_o, out_lane_o} !== {beats[0].data, beats[0].lane}) begin
                    errors++;
                    $display("[TB] FAIL stall_beat c=%0d: got %h/%0d want %h/%0d",
                             c, out_data_o, out_lane_o, beats[0].data, beats[0].lane);
                end
            end
            if (out_valid_o && out_ready_i) fired++;
            advance();
        end
        checks++;
        if (fired !== K) begin
            errors++;
            $display("[TB] FAIL stall_count: got %0d beats want %0d", fired, K);
        end
        out_ready_i = 1'b1;
    endtask

    task automatic test_third_vector();
        logic [DW-1:0] order[3];
        logic [DW-1:0] seen[$];
        int            idx, budget;
        bit            fire;
        order[0] = 4'd3; order[1] = 4'd5; order[2] = 4'd7;
        idx = 0; budget = 0;
        out_ready_i = 1'b1;
        rand_vector(); ctrl_warpid_i = order[0]; in_valid_i = 1'b1;
        while ((idx < 3 || beats.size() > 0) && budget < 80) begin
            budget++;
            checks++;
            if (in_ready_o !== model_ready()) begin
                errors++;
                $display("[TB] FAIL third_ready: got %b want %b", in_ready_o, model_ready());
            end
            if (beats.size() > 0) begin
                checks++;
                if ({ctrl_warpid_o, ctrl_c_o, ctrl_rm_o, ctrl_reg_idxw_o, out_data_o} !==
                    {beats[0].warpid, beats[0].ctrl_c, beats[0].rm, beats[0].idxw, beats[0].data}) begin
                    errors++;
                    $display("[TB] FAIL third_side: got warp=%0d c=%h data=%h want warp=%0d c=%h data=%h",
                             ctrl_warpid_o, ctrl_c_o, out_data_o, beats[0].warpid, beats[0].ctrl_c, beats[0].data);
                end
            end
            if (out_valid_o && out_last_o) seen.push_back(ctrl_warpid_o);
            fire = in_valid_i && model_ready();
            advance();
            if (fire) begin
                idx++;
                if (idx < 3) begin
                    rand_vector(); ctrl_warpid_i = order[idx];
                end else begin
                    in_valid_i = 1'b0;
                end
            end
        end
        checks++;
        if (budget >= 80) begin
            errors++;
            $display("[TB] FAIL third_timeout: got %0d cycles want fewer than 80", budget);
        end
        checks++;
        if (seen.size() != 3 || seen[0] !== order[0] || seen[1] !== order[1] || seen[2] !== order[2]) begin
            errors++;
            $display("[TB] FAIL third_order: got %0d last beats want warps 3,5,7", seen.size());
        end
    endtask

    task automatic test_fflags();
        logic [4:0] want;
        rand_vector();
        fflags_i = 5'b00101;
        in_valid_i = 1'b1; out_ready_i = 1'b1;
        advance();
        in_valid_i = 1'b0;
        for (int c = 1; c <= K; c++) begin
`ifdef TC_MUL_RX_FFLAGS_EN
            want = (c == K) ? 5'b00101 : 5'b00000;
`else
            want = 5'b00000;
`endif
            checks++;
            if (out_fflags_o !== want || beats[0].fflags !== want) begin
                errors++;
                $display("[TB] FAIL fflags c=%0d: got %b want %b", c, out_fflags_o, want);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        rand_vector(); in_valid_i = 1'b1; out_ready_i = 1'b0;
        advance();
        rand_vector();
        advance();
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        checks++;
        if (in_ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_full: got ready=%b want 0", in_ready_o);
        end
        advance(); advance(); advance();
        checks++;
        if (out_lane_o !== LW'(3) || out_data_o !== beats[0].data) begin
            errors++;
            $display("[TB] FAIL rstmid_beat4: got lane=%0d data=%h want lane=3 data=%h",
                     out_lane_o, out_data_o, beats[0].data);
        end
        rst = 1'b1;
        advance();
        rst = 1'b0;
        checks++;
        if ({out_valid_o, in_ready_o} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rstmid_after: got valid/ready=%b%b want 01", out_valid_o, in_ready_o);
        end
        for (int c = 0; c < 12; c++) begin
            advance();
            checks++;
            if (out_valid_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rstmid_stale c=%0d: got valid=%b data=%h want valid=0", c, out_valid_o, out_data_o);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rand_vector();
            in_valid_i  = ($urandom_range(1, 0) == 1);
            out_ready_i = ($urandom_range(9, 0) < 7);
            checks++;
            if ({in_ready_o, out_valid_o} !== {model_ready(), beats.size() > 0}) begin
                errors++;
                $display("[TB] FAIL rand_hs c=%0d: got ready/valid=%b%b want %b%b",
                         c, in_ready_o, out_valid_o, model_ready(), beats.size() > 0);
            end
            if (beats.size() > 0) begin
                checks++;
                if ({out_data_o, out_lane_o, out_last_o, out_fflags_o, ctrl_c_o, ctrl_rm_o, ctrl_reg_idxw_o, ctrl_warpid_o} !==
                    {beats[0].data, beats[0].lane, beats[0].last, beats[0].fflags, beats[0].ctrl_c,
                     beats[0].rm, beats[0].idxw, beats[0].warpid}) begin
                    errors++;
                    $display("[TB] FAIL rand_beat c=%0d: got data=%h lane=%0d last=%b ff=%b warp=%0d want data=%h lane=%0d last=%b ff=%b warp=%0d",
                             c, out_data_o, out_lane_o, out_last_o, out_fflags_o, ctrl_warpid_o,
                             beats[0].data, beats[0].lane, beats[0].last, beats[0].fflags, beats[0].warpid);
                end
            end
            advance();
        end
        in_valid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
        result_i = '0; fflags_i = '0; ctrl_c_i = '0; ctrl_rm_i = '0;
        ctrl_reg_idxw_i = '0; ctrl_warpid_i = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_third_vector();
        test_fflags();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
